// File: rtl/pe_pool_pkg.sv
// Shared types and helpers for the pe_pool max/sum pooling unit.
// Sum mode is compiled in only when PE_POOL_SUM_EN is defined.
package pe_pool_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_SUM = 1'b1;

  localparam int INIT_W = 64;

  // Accumulator start value: most negative DATA_WIDTH value (sign-extended) for max, zero for sum.
  function automatic logic [INIT_W-1:0] acc_init(input logic mode, input int unsigned data_width);
    logic [INIT_W-1:0] v;
    v = '0;
    if (mode == POOL_MAX) begin
      v = ~((64'd1 << (data_width - 1)) - 64'd1);
    end
    return v;
  endfunction

endpackage

// File: rtl/pe_pool_lane.sv
// One pooling lane: a 2*DATA_WIDTH signed accumulator doing max or (with PE_POOL_SUM_EN) sum.
// Sequencing is owned by pe_pool; this block only reacts to init/update.
module pe_pool_lane
  import pe_pool_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          init,
  input  logic                          update,
  input  logic                          mode,
  input  logic [DATA_WIDTH-1:0]         data,
  output logic signed [2*DATA_WIDTH-1:0] acc
);

  localparam int ACC_W = 2 * DATA_WIDTH;

  logic signed [ACC_W-1:0] beat_ext;
  logic signed [ACC_W-1:0] init_val;

  assign beat_ext = {{DATA_WIDTH{data[DATA_WIDTH-1]}}, data};
  assign init_val = ACC_W'(acc_init(mode, DATA_WIDTH));

  // Both operands are sign-extended, so a plain signed compare cannot overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (init) begin
      acc <= init_val;
    end else if (update) begin
`ifdef PE_POOL_SUM_EN
      if (mode == POOL_SUM) begin
        acc <= acc + beat_ext;
      end else if (beat_ext > acc) begin
        acc <= beat_ext;
      end
`else
      if (beat_ext > acc) begin
        acc <= beat_ext;
      end
`endif
    end
  end

endmodule

// File: rtl/pe_pool.sv
// Multi-lane pooling unit: accumulates windows of beats per lane and hands out one result per window.
// Define PE_POOL_SUM_EN to add sum mode; otherwise the block is max-only and i_mode is ignored.
module pe_pool
  import pe_pool_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int DATA_COPIES = 32,
  parameter int WIN_MAX     = 16,
  parameter int WS_W        = $clog2(WIN_MAX + 1)
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_pool_start,
  input  logic                              i_pool_stop,
  input  logic [WS_W-1:0]                   i_win_size,
  input  logic                              i_mode,
  input  logic [DATA_COPIES*DATA_WIDTH-1:0] i_mdata,
  input  logic                              i_mdata_vld,
  output logic                              o_mdata_rdy,
  output logic [DATA_COPIES*2*DATA_WIDTH-1:0] o_pool_result,
  output logic                              o_pool_vld,
  input  logic                              i_result_rdy,
  output logic                              o_busy
);

  state_t          state_q, state_d;
  logic [WS_W-1:0] cnt_q, cnt_d;
  logic [WS_W-1:0] ws_q, ws_d;
  logic            stop_q, stop_d;
  logic [WS_W-1:0] size_eff;
  logic            lane_init;
  logic            lane_update;
  logic            lane_mode;

  always_comb begin
    if (i_win_size == '0) begin
      size_eff = WS_W'(1);
    end else if (i_win_size > WS_W'(WIN_MAX)) begin
      size_eff = WS_W'(WIN_MAX);
    end else begin
      size_eff = i_win_size;
    end
  end

`ifdef PE_POOL_SUM_EN
  logic mode_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mode_q <= POOL_MAX;
    end else if (state_q == IDLE && i_pool_start) begin
      mode_q <= i_mode;
    end
  end

  // While idle the lanes initialise with the mode being latched this very cycle.
  assign lane_mode = (state_q == IDLE) ? i_mode : mode_q;
`else
  logic unused_mode;
  assign unused_mode = i_mode;
  assign lane_mode   = POOL_MAX;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ws_q    <= '0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ws_q    <= ws_d;
      stop_q  <= stop_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ws_d        = ws_q;
    stop_d      = stop_q;
    lane_init   = 1'b0;
    lane_update = 1'b0;
    o_mdata_rdy = 1'b0;
    o_pool_vld  = 1'b0;

    unique case (state_q)
      IDLE: begin
        stop_d = 1'b0;
        if (i_pool_start) begin
          ws_d      = size_eff;
          cnt_d     = '0;
          lane_init = 1'b1;
          state_d   = ACC;
        end
      end

      ACC: begin
        o_mdata_rdy = 1'b1;
        // A stop beats a coincident final beat: the whole window is dropped.
        if (i_pool_stop) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (i_mdata_vld) begin
          lane_update = 1'b1;
          if (cnt_q == ws_q - WS_W'(1)) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + WS_W'(1);
          end
        end
      end

      HOLD: begin
        o_pool_vld = 1'b1;
        if (i_pool_stop) begin
          stop_d = 1'b1;
        end
        if (i_result_rdy) begin
          if (stop_q || i_pool_stop) begin
            stop_d  = 1'b0;
            state_d = IDLE;
          end else begin
            lane_init = 1'b1;
            state_d   = ACC;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_busy = (state_q != IDLE);

  for (genvar k = 0; k < DATA_COPIES; k++) begin : g_lane
    pe_pool_lane #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_lane (
      .clk    (i_clk),
      .rst    (i_rst),
      .init   (lane_init),
      .update (lane_update),
      .mode   (lane_mode),
      .data   (i_mdata[DATA_WIDTH*k +: DATA_WIDTH]),
      .acc    (o_pool_result[2*DATA_WIDTH*k +: 2*DATA_WIDTH])
    );
  end

endmodule
